// File: rtl/riscv_dmem_resp_pkg.sv
// Shared types for the data-memory responder: funct3 access codes, FSM states
// and the latched request record.
package riscv_dmem_resp_pkg;

    typedef enum logic [2:0] {
        MEMOP_B  = 3'b000,
        MEMOP_H  = 3'b001,
        MEMOP_W  = 3'b010,
        MEMOP_BU = 3'b100,
        MEMOP_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic        we;
        logic [2:0]  op;
        logic [31:0] off;
        logic [31:0] wdata;
    } dmem_req_t;

    // Unsigned variants only make sense for loads; undefined codes are never legal.
    function automatic logic op_legal(input logic [2:0] op, input logic is_store);
        case (op)
            MEMOP_B, MEMOP_H, MEMOP_W: op_legal = 1'b1;
            MEMOP_BU, MEMOP_HU:        op_legal = !is_store;
            default:                   op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mem_align.sv
// Combinational lane logic: store byte enables and merge, load extraction with
// sign/zero extension, and the misalignment flag.
module riscv_mem_align
    import riscv_dmem_resp_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] wrep;

    assign rbyte = rword_i[{lane_i, 3'b000} +: 8];
    assign rhalf = rword_i[{lane_i[1], 4'b0000} +: 16];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be_o       = 4'b0000;
        wrep       = wdata_i;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (mem_op_i)
            MEMOP_B, MEMOP_BU: begin
                be_o    = 4'b0001 << lane_i;
                wrep    = {4{wdata_i[7:0]}};
                rdata_o = (mem_op_i == MEMOP_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
            end
            MEMOP_H, MEMOP_HU: begin
                be_o       = 4'b0011 << lane_i;
                wrep       = {2{wdata_i[15:0]}};
                rdata_o    = (mem_op_i == MEMOP_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
                misalign_o = lane_i[0];
            end
            MEMOP_W: begin
                be_o       = 4'b1111;
                rdata_o    = rword_i;
                misalign_o = (lane_i != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        wword_o = rword_i;
        for (int i = 0; i < 4; i++) begin
            if (be_o[i]) wword_o[8*i +: 8] = wrep[8*i +: 8];
        end
    end

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, completes it LATENCY
// cycles after accept with a one-cycle ready pulse, and owns the word storage.
module riscv_dmem_resp
    import riscv_dmem_resp_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  mem_op_i,
    output logic [31:0] data_o,
    output logic        data_ready_o,
    output logic        data_err_o,
    output logic        busy_o
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [31:0]      LIMIT    = 32'(DEPTH * 4);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic [31:0]      data_q, data_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      rword, wword, load_data;
    logic [3:0]       be;
    logic             misalign, req_err, complete;

    assign idx   = req_q.off[IDX_W+1:2];
    assign lane  = req_q.off[1:0];
    assign rword = mem[idx];

    riscv_mem_align u_align (
        .lane_i     (lane),
        .mem_op_i   (req_q.op),
        .wdata_i    (req_q.wdata),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (load_data),
        .misalign_o (misalign)
    );

    // The offset subtraction wraps, so addresses below BASE land far above LIMIT.
    assign req_err  = (req_q.off >= LIMIT) | misalign | !op_legal(req_q.op, req_q.we);
    assign complete = (state_q == ST_WAIT) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        busy_d  = busy_q;
        data_d  = '0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_ce_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    req_d   = '{we: data_we_i, op: mem_op_i,
                                off: data_addr_i - BASE, wdata: data_i};
                end
            end
            ST_WAIT: begin
                if (complete) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    err_d   = req_err;
                    data_d  = (req_err || req_q.we) ? '0 : load_data;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: storage is deliberately not reset; rst only gates the write so an
    // interrupted store is dropped.
    always_ff @(posedge clk) begin
        if (!rst && complete && req_q.we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    assign data_o       = data_q;
    assign data_ready_o = ready_q;
    assign data_err_o   = err_q;
    assign busy_o       = busy_q;

endmodule
